// File: rtl/uart_defs_pkg.sv
// Shared definitions for the RS-232 link: receiver state encodings,
// default bit period and frame format. uart_tx uses the same constants.
package uart_defs;

    // Receiver states, kept at 3 bits so the encoding is stable across blocks
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        RECOVER = 3'd4
    } uart_state_t;

    // Bit period minus one; 433 gives 115200 baud from a 50 MHz clock
    localparam int DEFAULT_CLOCK_BIT = 433;

    // 8N1 frame format
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for bringing an asynchronous single-bit input
// into the clock domain. The reset value is chosen by the instantiator
// so an idle-high line does not look like a falling edge out of reset.
module uart_sync #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops give the first stage a full cycle to settle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Each bit is sampled at its midpoint: the start bit
// is re-checked half a bit after the falling edge (glitch rejection), and
// every later bit is taken one full bit period after the previous sample.
// A low stop bit reports a framing error and then waits for the line to
// return high so a break condition cannot re-trigger reception.
module uart_rx
    import uart_defs::*;
#(
    parameter int clock_bit = DEFAULT_CLOCK_BIT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    input  logic       enable,
    output logic [7:0] readdata,
    output logic       done,
    output logic       error,
    output logic       active
);

    // Last count of a full bit and of the half-bit offset to the midpoint
    localparam int         BIT_CYCLES = clock_bit + 1;
    localparam logic [15:0] BIT_LAST  = 16'(clock_bit);
    localparam logic [15:0] HALF_LAST = 16'((BIT_CYCLES / 2) - 1);
    localparam logic [2:0]  LAST_INDEX = 3'(DATA_BITS - 1);

    uart_state_t state;
    logic [15:0] counter;
    logic [2:0]  index;
    logic [7:0]  shift;
    logic        rx_s;

    uart_sync #(
        .RESET_VALUE(1'b1)
    ) syncInst (
        .clock (clock),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // Frame sequencer: bit timing, deserialisation and registered status pulses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            counter  <= 16'd0;
            index    <= 3'd0;
            shift    <= 8'h00;
            readdata <= 8'h00;
            done     <= 1'b0;
            error    <= 1'b0;
            active   <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable && !rx_s) begin
                        state   <= START;
                        counter <= 16'd0;
                        active  <= 1'b1;
                    end
                end
                START: begin
                    if (counter == HALF_LAST) begin
                        counter <= 16'd0;
                        if (!rx_s) begin
                            index <= 3'd0;
                            state <= DATA;
                        end else begin
                            state  <= IDLE;
                            active <= 1'b0;
                        end
                    end else begin
                        counter <= counter + 16'd1;
                    end
                end
                DATA: begin
                    if (counter == BIT_LAST) begin
                        counter      <= 16'd0;
                        shift[index] <= rx_s;
                        if (index == LAST_INDEX) begin
                            state <= STOP;
                        end else begin
                            index <= index + 3'd1;
                        end
                    end else begin
                        counter <= counter + 16'd1;
                    end
                end
                STOP: begin
                    if (counter == BIT_LAST) begin
                        counter <= 16'd0;
                        if (rx_s) begin
                            readdata <= shift;
                            done     <= 1'b1;
                            active   <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            error <= 1'b1;
                            state <= RECOVER;
                        end
                    end else begin
                        counter <= counter + 16'd1;
                    end
                end
                RECOVER: begin
                    if (rx_s) begin
                        state  <= IDLE;
                        active <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at clock_bit = 15 (16 cycles per bit).
// Frames are serialised by applyStimulus; a negedge monitor counts the
// done/error pulses and records when they occur.
module tb_uart_rx;

    localparam int CLOCK_BIT = 15;
    localparam int T = CLOCK_BIT + 1;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       enable = 1'b1;
    logic [7:0] readdata;
    logic       done;
    logic       error;
    logic       active;

    int vectors = 0;
    int miscompares = 0;

    int cycle = 0;
    int doneCount = 0;
    int errorCount = 0;
    int activeCycles = 0;
    int overlapCount = 0;
    int longPulseCount = 0;
    int doneTimes[$];
    logic prevDone = 1'b0;
    logic prevError = 1'b0;
    int lastFallCycle = 0;

    uart_rx #(
        .clock_bit(CLOCK_BIT)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .rx       (rx),
        .enable   (enable),
        .readdata (readdata),
        .done     (done),
        .error    (error),
        .active   (active)
    );

    always #5 clock = ~clock;

    // Monitor: observe outputs on the falling edge, away from the update edge
    always @(negedge clock) begin
        cycle = cycle + 1;
        if (done) begin
            doneCount = doneCount + 1;
            doneTimes.push_back(cycle);
        end
        if (error) errorCount = errorCount + 1;
        if (active) activeCycles = activeCycles + 1;
        if (done && error) overlapCount = overlapCount + 1;
        if ((done && prevDone) || (error && prevError)) longPulseCount = longPulseCount + 1;
        prevDone = done;
        prevError = error;
    end

    // Serialise one frame; bits alternate between two periods so a skewed
    // transmitter can be modelled (start bit uses evenPeriod, d0 oddPeriod)
    task automatic applyStimulus(input logic [7:0] data, input int evenPeriod,
                                 input int oddPeriod, input logic stopBit, input int stopLen);
        rx = 1'b0;
        #1 lastFallCycle = cycle;
        repeat (evenPeriod) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat ((i % 2 == 0) ? oddPeriod : evenPeriod) @(negedge clock);
        end
        rx = stopBit;
        repeat (stopLen) @(negedge clock);
        rx = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        vectors++;
        if ({readdata, done, error, active} !== 11'h000) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got %h/%b/%b/%b want 00/0/0/0", readdata, done, error, active);
        end
        reset = 1'b0;
        repeat (5) @(negedge clock);
    endtask

    task automatic test_loopback();
        logic [7:0] bytes [3] = '{8'hA5, 8'h00, 8'hFF};
        int d0, e0, latency;
        e0 = errorCount;
        for (int k = 0; k < 3; k++) begin
            d0 = doneCount;
            applyStimulus(bytes[k], T, T, 1'b1, T);
            repeat (10) @(negedge clock);
            vectors++;
            if (doneCount - d0 !== 1) begin
                miscompares++;
                $display("[TB] FAIL loopback_done_%0d: got %0d pulses want 1", k, doneCount - d0);
            end
            vectors++;
            if (readdata !== bytes[k]) begin
                miscompares++;
                $display("[TB] FAIL loopback_data_%0d: got %h want %h", k, readdata, bytes[k]);
            end
            if (k == 0 && doneTimes.size() > 0) begin
                latency = doneTimes[$] - lastFallCycle;
                vectors++;
                if (latency < 153 || latency > 156) begin
                    miscompares++;
                    $display("[TB] FAIL done_latency: got %0d cycles want 153..156", latency);
                end
            end
        end
        vectors++;
        if (errorCount != e0) begin
            miscompares++;
            $display("[TB] FAIL loopback_error: got %0d pulses want 0", errorCount - e0);
        end
    endtask

    task automatic test_glitch();
        int d0 = doneCount, e0 = errorCount, a0 = activeCycles;
        rx = 1'b0;
        repeat (4) @(negedge clock);
        rx = 1'b1;
        repeat (30) @(negedge clock);
        vectors++;
        if (activeCycles - a0 < 1 || activeCycles - a0 > 15) begin
            miscompares++;
            $display("[TB] FAIL glitch_active: got %0d active cycles want 1..15", activeCycles - a0);
        end
        vectors++;
        if (doneCount != d0 || errorCount != e0 || active !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL glitch_quiet: got done %0d error %0d active %b want 0 0 0",
                     doneCount - d0, errorCount - e0, active);
        end
    endtask

    task automatic test_framing_error();
        int d0 = doneCount, e0 = errorCount;
        applyStimulus(8'h3C, T, T, 1'b0, 40);
        vectors++;
        if (active !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL recover_active: got %b want 1", active);
        end
        repeat (6) @(negedge clock);
        vectors++;
        if (errorCount - e0 !== 1 || doneCount != d0) begin
            miscompares++;
            $display("[TB] FAIL framing_pulses: got error %0d done %0d want 1 0", errorCount - e0, doneCount - d0);
        end
        vectors++;
        if (readdata !== 8'hFF || active !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL framing_hold: got data %h active %b want ff 0", readdata, active);
        end
        d0 = doneCount;
        applyStimulus(8'h81, T, T, 1'b1, T);
        repeat (10) @(negedge clock);
        vectors++;
        if (doneCount - d0 !== 1 || readdata !== 8'h81) begin
            miscompares++;
            $display("[TB] FAIL after_error_frame: got done %0d data %h want 1 81", doneCount - d0, readdata);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] data = 8'h5A;
        int d0 = doneCount, e0 = errorCount;
        rx = 1'b0;
        repeat (T) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            rx = data[i];
            repeat (T) @(negedge clock);
        end
        rx = data[3];
        repeat (T / 2) @(negedge clock);
        reset = 1'b1;
        rx = 1'b1;
        #1;
        vectors++;
        if ({readdata, done, error, active} !== 11'h000) begin
            miscompares++;
            $display("[TB] FAIL midframe_reset: got %h/%b/%b/%b want 00/0/0/0", readdata, done, error, active);
        end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (30) @(negedge clock);
        vectors++;
        if (doneCount != d0 || errorCount != e0) begin
            miscompares++;
            $display("[TB] FAIL midframe_pulse: got done %0d error %0d want 0 0", doneCount - d0, errorCount - e0);
        end
        applyStimulus(8'h5A, T, T, 1'b1, T);
        repeat (10) @(negedge clock);
        vectors++;
        if (doneCount - d0 !== 1 || readdata !== 8'h5A) begin
            miscompares++;
            $display("[TB] FAIL midframe_next: got done %0d data %h want 1 5a", doneCount - d0, readdata);
        end
    endtask

    task automatic test_back_to_back();
        int d0 = doneCount, gap;
        applyStimulus(8'hC3, T, T, 1'b1, T);
        applyStimulus(8'h7E, T, T, 1'b1, T);
        repeat (10) @(negedge clock);
        vectors++;
        if (doneCount - d0 !== 2 || readdata !== 8'h7E) begin
            miscompares++;
            $display("[TB] FAIL b2b_frames: got done %0d data %h want 2 7e", doneCount - d0, readdata);
        end else begin
            gap = doneTimes[$] - doneTimes[$-1];
            vectors++;
            if (gap < 10 * T - 1 || gap > 10 * T + 1) begin
                miscompares++;
                $display("[TB] FAIL b2b_spacing: got %0d cycles want 159..161", gap);
            end
        end
    endtask

    task automatic test_enable_gating();
        int d0 = doneCount, a0 = activeCycles;
        enable = 1'b0;
        applyStimulus(8'h33, T, T, 1'b1, T);
        repeat (10) @(negedge clock);
        vectors++;
        if (activeCycles != a0 || doneCount != d0) begin
            miscompares++;
            $display("[TB] FAIL enable_block: got active %0d done %0d want 0 0", activeCycles - a0, doneCount - d0);
        end
        enable = 1'b1;
        d0 = doneCount;
        fork
            applyStimulus(8'h6B, T, T, 1'b1, T);
            begin
                repeat (40) @(negedge clock);
                enable = 1'b0;
            end
        join
        repeat (10) @(negedge clock);
        enable = 1'b1;
        vectors++;
        if (doneCount - d0 !== 1 || readdata !== 8'h6B) begin
            miscompares++;
            $display("[TB] FAIL enable_midframe: got done %0d data %h want 1 6b", doneCount - d0, readdata);
        end
    endtask

    task automatic test_baud_skew();
        int d0 = doneCount;
        applyStimulus(8'h96, 17, 17, 1'b1, 17);
        repeat (20) @(negedge clock);
        vectors++;
        if (doneCount - d0 !== 1 || readdata !== 8'h96) begin
            miscompares++;
            $display("[TB] FAIL skew_slow: got done %0d data %h want 1 96", doneCount - d0, readdata);
        end
        applyStimulus(8'h00, T, T, 1'b1, T);
        repeat (10) @(negedge clock);
        // Fast transmitter: bits alternate 16/15 cycles, about 3% short
        d0 = doneCount;
        applyStimulus(8'h96, 16, 15, 1'b1, 15);
        repeat (20) @(negedge clock);
        vectors++;
        if (doneCount - d0 !== 1 || readdata !== 8'h96) begin
            miscompares++;
            $display("[TB] FAIL skew_fast: got done %0d data %h want 1 96", doneCount - d0, readdata);
        end
    endtask

    task automatic test_pulse_shape();
        vectors++;
        if (overlapCount != 0 || longPulseCount != 0) begin
            miscompares++;
            $display("[TB] FAIL pulse_shape: got overlap %0d long %0d want 0 0", overlapCount, longPulseCount);
        end
    endtask

    // Scenario sequence
    initial begin
        @(negedge clock);
        test_reset();
        test_loopback();
        test_glitch();
        test_framing_error();
        test_reset_mid_frame();
        test_back_to_back();
        test_enable_gating();
        test_baud_skew();
        test_pulse_shape();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
